mdma_ram_ctl: RTL and testbench

MDMA_RAM_CTL -- requirements
Module: mdma_ram_ctl

---
 rtl/mdma_ram_ctl_pkg.sv | 26 ++
 rtl/mdma_40bx512_40bwe_ram_if.sv | 23 ++
 rtl/mdma_ram_ctl_scrub.sv | 84 ++++++++
 rtl/mdma_ram_ctl.sv | 219 +++++++++++++++++++++
 tb/tb_mdma_ram_ctl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdma_ram_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdma_ram_ctl_pkg
// Description : Shared widths, read-tag encoding and counter helper for the
//               40b x 512 ECC RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mdma_ram_ctl_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 40;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_RD0   = 2'd1,
        TAG_RD1   = 2'd2,
        TAG_SCRUB = 2'd3
    } tag_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdma_40bx512_40bwe_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : mdma_40bx512_40bwe_ram_if
// Description : Port bundle of the 40b x 512 ECC RAM (one write, one read port).
// Revision    : 1.0 - initial release
// ============================================================================
interface mdma_40bx512_40bwe_ram_if;
    import mdma_ram_ctl_pkg::*;

    logic [ADDR_W-1:0] wadr;
    logic              wen;
    logic [DATA_W-1:0] wdat;
    logic              ren;
    logic [ADDR_W-1:0] radr;
    logic [DATA_W-1:0] rdat;
    logic              rsbe;
    logic              rdbe;

    modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);
    modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);

endinterface
`default_nettype wire

// File: rtl/mdma_ram_ctl_scrub.sv
`default_nettype none
// ============================================================================
// Module      : mdma_ram_ctl_scrub
// Description : Background ECC scrubber; only built with MDMA_RAM_CTL_SCRUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mdma_ram_ctl_scrub
    import mdma_ram_ctl_pkg::*;
#(
    parameter int SCRUB_IDLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_client_req,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_busy,
    input  logic              i_ret,
    input  logic [DATA_W-1:0] i_rdat,
    input  logic              i_rsbe,
    input  logic              i_rdbe,
    output logic              o_scrub_ren,
    output logic [ADDR_W-1:0] o_scrub_addr,
    output logic              o_wb_en,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data
);

    localparam int                c_IDLE_W   = $clog2(SCRUB_IDLE + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(SCRUB_IDLE);

    logic [c_IDLE_W-1:0] r_idle;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_fl_addr;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0]   r_wb_data;
    logic                w_issue;
    logic                w_capture;

    // One scrub in flight at a time, and never onto a word being written now.
    assign w_issue = !i_client_req && (r_idle == c_IDLE_MAX) && !r_pend && !i_busy
                     && !(i_wr_req && (i_wr_addr == r_addr));

    // Uncorrectable words are only counted; a same-cycle client write supersedes.
    assign w_capture = i_ret && i_rsbe && !i_rdbe
                       && !(i_wr_req && (i_wr_addr == r_fl_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle    <= '0;
            r_addr    <= '0;
            r_fl_addr <= '0;
            r_pend    <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            if (i_client_req || w_issue) begin
                r_idle <= '0;
            end else if (r_idle != c_IDLE_MAX) begin
                r_idle <= r_idle + c_IDLE_W'(1);
            end
            if (w_issue) begin
                r_addr    <= r_addr + ADDR_W'(1);
                r_fl_addr <= r_addr;
            end
            if (w_capture) begin
                r_pend    <= 1'b1;
                r_wb_addr <= r_fl_addr;
                r_wb_data <= i_rdat;
            end else if (r_pend && (!i_wr_req || (i_wr_addr == r_wb_addr))) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_scrub_ren  = w_issue;
    assign o_scrub_addr = r_addr;
    assign o_wb_en      = r_pend && !i_wr_req;
    assign o_wb_addr    = r_wb_addr;
    assign o_wb_data    = r_wb_data;

endmodule
`default_nettype wire

// File: rtl/mdma_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module      : mdma_ram_ctl
// Description : ECC RAM controller: 1 write + 2 round-robin read clients,
//               error counters; scrubber when MDMA_RAM_CTL_SCRUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mdma_ram_ctl
    import mdma_ram_ctl_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int SCRUB_IDLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    output logic              wr_gnt,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_req,
    output logic              rd0_gnt,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_vld,
    output logic [DATA_W-1:0] rd0_data,
    output logic [1:0]        rd0_err,
    input  logic              rd1_req,
    output logic              rd1_gnt,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_vld,
    output logic [DATA_W-1:0] rd1_data,
    output logic [1:0]        rd1_err,
    mdma_40bx512_40bwe_ram_if.m ram,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt,
    input  logic              err_clr
);

    logic              w_rd0_ok, w_rd1_ok, w_gnt0, w_gnt1;
    logic              r_rr_ptr;
    tag_t              r_tag [RD_LAT];
    tag_t              w_new_tag, w_ret_tag;
    logic              w_ret, w_vld0, w_vld1;
    logic [DATA_W-1:0] r_data0, r_data1;
    logic [1:0]        r_err0, r_err1;
    logic [CNT_W-1:0]  r_sbe_cnt, r_dbe_cnt;
    logic              w_scrub_ren, w_wb_en;
    logic [ADDR_W-1:0] w_scrub_addr, w_wb_addr;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_ren, w_wen;
    logic [ADDR_W-1:0] w_radr, w_wadr;
    logic [DATA_W-1:0] w_wdat;

    // A read colliding with the current write waits a cycle so it sees new data.
    assign w_rd0_ok = !rst && rd0_req && !(wr_req && (wr_addr == rd0_addr));
    assign w_rd1_ok = !rst && rd1_req && !(wr_req && (wr_addr == rd1_addr));

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_rd0_ok && (!w_rd1_ok || !r_rr_ptr)) begin
            w_gnt0 = 1'b1;
        end else if (w_rd1_ok) begin
            w_gnt1 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr_ptr <= 1'b0;
        end
    end

`ifdef MDMA_RAM_CTL_SCRUB_EN
    logic w_scrub_busy;

    always_comb begin
        w_scrub_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (r_tag[i] == TAG_SCRUB) begin
                w_scrub_busy = 1'b1;
            end
        end
    end

    mdma_ram_ctl_scrub #(
        .SCRUB_IDLE (SCRUB_IDLE)
    ) u_scrub (
        .clk          (clk),
        .rst          (rst),
        .i_client_req (rd0_req | rd1_req),
        .i_wr_req     (wr_req),
        .i_wr_addr    (wr_addr),
        .i_busy       (w_scrub_busy),
        .i_ret        (w_ret_tag == TAG_SCRUB),
        .i_rdat       (ram.rdat),
        .i_rsbe       (ram.rsbe),
        .i_rdbe       (ram.rdbe),
        .o_scrub_ren  (w_scrub_ren),
        .o_scrub_addr (w_scrub_addr),
        .o_wb_en      (w_wb_en),
        .o_wb_addr    (w_wb_addr),
        .o_wb_data    (w_wb_data)
    );
`else
    localparam logic [31:0] c_SCRUB_IDLE = SCRUB_IDLE;
    logic w_unused_cfg;

    assign w_unused_cfg = ^c_SCRUB_IDLE;
    assign w_scrub_ren  = 1'b0;
    assign w_scrub_addr = '0;
    assign w_wb_en      = 1'b0;
    assign w_wb_addr    = '0;
    assign w_wb_data    = '0;
`endif

    always_comb begin
        w_ren     = 1'b0;
        w_radr    = '0;
        w_new_tag = TAG_NONE;
        if (w_gnt0) begin
            w_ren = 1'b1; w_radr = rd0_addr; w_new_tag = TAG_RD0;
        end else if (w_gnt1) begin
            w_ren = 1'b1; w_radr = rd1_addr; w_new_tag = TAG_RD1;
        end else if (w_scrub_ren && !rst) begin
            w_ren = 1'b1; w_radr = w_scrub_addr; w_new_tag = TAG_SCRUB;
        end
    end

    always_comb begin
        w_wen  = 1'b0;
        w_wadr = '0;
        w_wdat = '0;
        if (!rst && wr_req) begin
            w_wen = 1'b1; w_wadr = wr_addr; w_wdat = wr_data;
        end else if (!rst && w_wb_en) begin
            w_wen = 1'b1; w_wadr = w_wb_addr; w_wdat = w_wb_data;
        end
    end

    assign wr_gnt   = wr_req && !rst;
    assign rd0_gnt  = w_gnt0;
    assign rd1_gnt  = w_gnt1;
    assign ram.ren  = w_ren;
    assign ram.radr = w_radr;
    assign ram.wen  = w_wen;
    assign ram.wadr = w_wadr;
    assign ram.wdat = w_wdat;

    // Tag position RD_LAT-1 lines up with the cycle rdat is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= TAG_NONE;
            end
        end else begin
            r_tag[0] <= w_new_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_ret_tag = r_tag[RD_LAT-1];
    assign w_ret     = (w_ret_tag != TAG_NONE);
    assign w_vld0    = (w_ret_tag == TAG_RD0);
    assign w_vld1    = (w_ret_tag == TAG_RD1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data0 <= '0;
            r_err0  <= '0;
            r_data1 <= '0;
            r_err1  <= '0;
        end else begin
            if (w_vld0) begin
                r_data0 <= ram.rdat;
                r_err0  <= {ram.rdbe, ram.rsbe};
            end
            if (w_vld1) begin
                r_data1 <= ram.rdat;
                r_err1  <= {ram.rdbe, ram.rsbe};
            end
        end
    end

    // Data passes straight through on the valid cycle, then holds.
    assign rd0_vld  = w_vld0;
    assign rd1_vld  = w_vld1;
    assign rd0_data = w_vld0 ? ram.rdat : r_data0;
    assign rd1_data = w_vld1 ? ram.rdat : r_data1;
    assign rd0_err  = w_vld0 ? {ram.rdbe, ram.rsbe} : r_err0;
    assign rd1_err  = w_vld1 ? {ram.rdbe, ram.rsbe} : r_err1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sbe_cnt <= '0;
            r_dbe_cnt <= '0;
        end else if (err_clr) begin
            r_sbe_cnt <= '0;
            r_dbe_cnt <= '0;
        end else begin
            if (w_ret && ram.rsbe) begin
                r_sbe_cnt <= sat_inc(r_sbe_cnt);
            end
            if (w_ret && ram.rdbe) begin
                r_dbe_cnt <= sat_inc(r_dbe_cnt);
            end
        end
    end

    assign sbe_cnt = r_sbe_cnt;
    assign dbe_cnt = r_dbe_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mdma_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdma_ram_ctl
// Description : Directed self-checking bench for mdma_ram_ctl with a latency
//               RAM model; scrub scenario when MDMA_RAM_CTL_SCRUB_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdma_ram_ctl;
    import mdma_ram_ctl_pkg::*;

    localparam int TB_RD_LAT     = 2;
    localparam int TB_SCRUB_IDLE = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd0_req = 1'b0, rd1_req = 1'b0;
    logic [ADDR_W-1:0] rd0_addr = '0, rd1_addr = '0;
    logic              err_clr = 1'b0;
    logic              wr_gnt, rd0_gnt, rd1_gnt, rd0_vld, rd1_vld;
    logic [DATA_W-1:0] rd0_data, rd1_data;
    logic [1:0]        rd0_err, rd1_err;
    logic [CNT_W-1:0]  sbe_cnt, dbe_cnt;

    logic              inj_sbe = 1'b0, inj_dbe = 1'b0, sbe_at_en = 1'b0;
    logic [ADDR_W-1:0] sbe_at = '0;

    int checks = 0;
    int errors = 0;

    mdma_40bx512_40bwe_ram_if ram_if ();

    mdma_ram_ctl #(
        .RD_LAT     (TB_RD_LAT),
        .SCRUB_IDLE (TB_SCRUB_IDLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_gnt   (wr_gnt),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd0_req  (rd0_req),
        .rd0_gnt  (rd0_gnt),
        .rd0_addr (rd0_addr),
        .rd0_vld  (rd0_vld),
        .rd0_data (rd0_data),
        .rd0_err  (rd0_err),
        .rd1_req  (rd1_req),
        .rd1_gnt  (rd1_gnt),
        .rd1_addr (rd1_addr),
        .rd1_vld  (rd1_vld),
        .rd1_data (rd1_data),
        .rd1_err  (rd1_err),
        .ram      (ram_if),
        .sbe_cnt  (sbe_cnt),
        .dbe_cnt  (dbe_cnt),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {8'hA5, 7'h00, a, 7'h00, a ^ 9'h1FF};
    endfunction

    // RAM model: unwritten words read as pat(addr); errors tagged at issue.
    bit [DATA_W-1:0] mem  [512];
    bit              wrt  [512];
    bit [DATA_W+1:0] pipe [TB_RD_LAT];

    always @(posedge clk) begin
        if (ram_if.wen) begin
            mem[ram_if.wadr] <= ram_if.wdat;
            wrt[ram_if.wadr] <= 1'b1;
        end
        if (ram_if.ren)
            pipe[0] <= {inj_dbe, inj_sbe | (sbe_at_en & (ram_if.radr == sbe_at)),
                        wrt[ram_if.radr] ? mem[ram_if.radr] : pat(ram_if.radr)};
        else
            pipe[0] <= '0;
        for (int i = 1; i < TB_RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign ram_if.rdat = pipe[TB_RD_LAT-1][DATA_W-1:0];
    assign ram_if.rsbe = pipe[TB_RD_LAT-1][DATA_W];
    assign ram_if.rdbe = pipe[TB_RD_LAT-1][DATA_W+1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = 0; rd0_req = 0; rd1_req = 0; err_clr = 0;
        inj_sbe = 0; inj_dbe = 0; sbe_at_en = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        wr_req = 1; wr_addr = 9'h011; rd0_req = 1; rd0_addr = 9'h022; rd1_req = 1; rd1_addr = 9'h033;
        @(negedge clk);
        checks++;
        if ({wr_gnt, rd0_gnt, rd1_gnt} !== 3'b000) begin
            errors++; $display("FAIL reset_grants: got %b expected 000", {wr_gnt, rd0_gnt, rd1_gnt});
        end
        checks++;
        if ({ram_if.ren, ram_if.wen, ram_if.radr, ram_if.wadr, ram_if.wdat} !== '0) begin
            errors++; $display("FAIL reset_ram_port: ren=%b wen=%b radr=%h wadr=%h expected all 0",
                               ram_if.ren, ram_if.wen, ram_if.radr, ram_if.wadr);
        end
        checks++;
        if ({rd0_vld, rd1_vld, rd0_err, rd1_err} !== 6'b0) begin
            errors++; $display("FAIL reset_vld_err: got %b expected 0", {rd0_vld, rd1_vld, rd0_err, rd1_err});
        end
        checks++;
        if ({rd0_data, rd1_data, sbe_cnt, dbe_cnt} !== '0) begin
            errors++; $display("FAIL reset_data_cnt: d0=%h d1=%h sbe=%h dbe=%h expected 0",
                               rd0_data, rd1_data, sbe_cnt, dbe_cnt);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic eg0, eg1, ev0, ev1;
        do_reset();
        rd0_addr = 9'h010; rd1_addr = 9'h020;
        for (int k = 0; k < 10; k++) begin
            rd0_req = (k < 8); rd1_req = (k < 8);
            @(negedge clk);
            eg0 = (k < 8) && (k % 2 == 0);
            eg1 = (k < 8) && (k % 2 == 1);
            ev0 = (k >= 2) && (k % 2 == 0);
            ev1 = (k >= 3) && (k % 2 == 1);
            checks++;
            if ({rd0_gnt, rd1_gnt} !== {eg0, eg1}) begin
                errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, {rd0_gnt, rd1_gnt}, {eg0, eg1});
            end
            checks++;
            if ({rd0_vld, rd1_vld} !== {ev0, ev1}) begin
                errors++; $display("FAIL rr_vld[%0d]: got %b expected %b", k, {rd0_vld, rd1_vld}, {ev0, ev1});
            end
            if (k < 8) begin
                checks++;
                if (ram_if.radr !== ((k % 2 == 1) ? 9'h020 : 9'h010)) begin
                    errors++; $display("FAIL rr_radr[%0d]: got %h", k, ram_if.radr);
                end
            end
            if (ev0) begin
                checks++;
                if (rd0_data !== pat(9'h010)) begin
                    errors++; $display("FAIL rr_data0[%0d]: got %h expected %h", k, rd0_data, pat(9'h010));
                end
            end
            if (ev1) begin
                checks++;
                if (rd1_data !== pat(9'h020)) begin
                    errors++; $display("FAIL rr_data1[%0d]: got %h expected %h", k, rd1_data, pat(9'h020));
                end
            end
            step();
        end
    endtask

    task automatic test_hazard();
        do_reset();
        wr_req = 1; wr_addr = 9'h055; wr_data = 40'h12_3456_789A;
        rd0_req = 1; rd0_addr = 9'h055;
        @(negedge clk);
        checks++;
        if ({wr_gnt, rd0_gnt} !== 2'b10) begin
            errors++; $display("FAIL haz_gnt: got wr/rd0=%b expected 10", {wr_gnt, rd0_gnt});
        end
        checks++;
        if ({ram_if.wen, ram_if.wadr, ram_if.wdat} !== {1'b1, 9'h055, 40'h12_3456_789A}) begin
            errors++; $display("FAIL haz_wport: got wen=%b wadr=%h wdat=%h expected 1 055 123456789a",
                               ram_if.wen, ram_if.wadr, ram_if.wdat);
        end
        step();
        wr_req = 0;
        @(negedge clk);
        checks++;
        if ({rd0_gnt, ram_if.ren, ram_if.radr} !== {2'b11, 9'h055}) begin
            errors++; $display("FAIL haz_defer: got gnt=%b ren=%b radr=%h expected 1 1 055",
                               rd0_gnt, ram_if.ren, ram_if.radr);
        end
        step();
        rd0_req = 0;
        @(negedge clk);
        checks++;
        if (rd0_vld !== 1'b0) begin
            errors++; $display("FAIL haz_early_vld: got %b expected 0", rd0_vld);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rd0_vld, rd0_data} !== {1'b1, 40'h12_3456_789A}) begin
            errors++; $display("FAIL haz_data: got vld=%b data=%h expected 1 123456789a", rd0_vld, rd0_data);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rd0_vld, rd0_data} !== {1'b0, 40'h12_3456_789A}) begin
            errors++; $display("FAIL haz_hold: got vld=%b data=%h expected 0 123456789a", rd0_vld, rd0_data);
        end
        step();
    endtask

    task automatic test_err_count();
        logic [1:0] exp_err [5];
        exp_err[0] = 2'b01; exp_err[1] = 2'b01; exp_err[2] = 2'b01; exp_err[3] = 2'b10; exp_err[4] = 2'b00;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            rd0_req = (k < 5); rd0_addr = 9'(k + 9'h100);
            inj_sbe = (k < 3); inj_dbe = (k == 3);
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if ({rd0_vld, rd0_err} !== {1'b1, exp_err[k-2]}) begin
                    errors++; $display("FAIL err_flags[%0d]: got vld=%b err=%b expected 1 %b",
                                       k, rd0_vld, rd0_err, exp_err[k-2]);
                end
            end
            step();
        end
        inj_sbe = 0; inj_dbe = 0;
        @(negedge clk);
        checks++;
        if ({sbe_cnt, dbe_cnt} !== {16'd3, 16'd1}) begin
            errors++; $display("FAIL err_counts: got sbe=%0d dbe=%0d expected 3 1", sbe_cnt, dbe_cnt);
        end
        step();
        rd0_req = 1; inj_sbe = 1;
        step();
        rd0_req = 0; inj_sbe = 0;
        step();
        err_clr = 1;
        @(negedge clk);
        checks++;
        if (ram_if.rsbe !== 1'b1) begin
            errors++; $display("FAIL clr_setup_rsbe: got %b expected 1", ram_if.rsbe);
        end
        step();
        err_clr = 0;
        @(negedge clk);
        checks++;
        if ({sbe_cnt, dbe_cnt} !== 32'd0) begin
            errors++; $display("FAIL err_clr_prio: got sbe=%0d dbe=%0d expected 0 0", sbe_cnt, dbe_cnt);
        end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        rd0_req = 1; rd0_addr = 9'h0AA; inj_sbe = 1;
        repeat (65535) step();
        rd0_req = 0; inj_sbe = 0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({sbe_cnt, dbe_cnt} !== {16'hFFFF, 16'h0000}) begin
            errors++; $display("FAIL sat_preload: got sbe=%h dbe=%h expected ffff 0000", sbe_cnt, dbe_cnt);
        end
        step();
        rd0_req = 1; inj_sbe = 1;
        step();
        rd0_req = 0; inj_sbe = 0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (sbe_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got sbe=%h expected ffff", sbe_cnt);
        end
        step();
    endtask

    task automatic test_reset_inflight();
        rd1_req = 1; rd1_addr = 9'h020;
        @(negedge clk);
        checks++;
        if (rd1_gnt !== 1'b1) begin
            errors++; $display("FAIL rif_gnt: got %b expected 1", rd1_gnt);
        end
        step();
        rst = 1; rd1_req = 0; rd0_req = 1; rd0_addr = 9'h030; wr_req = 1; wr_addr = 9'h040;
        @(negedge clk);
        checks++;
        if ({wr_gnt, rd0_gnt, rd1_gnt, rd0_vld, rd1_vld, rd0_err, rd1_err, ram_if.ren, ram_if.wen} !== '0) begin
            errors++; $display("FAIL rif_ctrl_zero: got %b expected 0",
                               {wr_gnt, rd0_gnt, rd1_gnt, rd0_vld, rd1_vld, rd0_err, rd1_err, ram_if.ren, ram_if.wen});
        end
        checks++;
        if ({rd0_data, rd1_data, sbe_cnt, dbe_cnt} !== '0) begin
            errors++; $display("FAIL rif_data_zero: d0=%h d1=%h sbe=%h dbe=%h expected 0",
                               rd0_data, rd1_data, sbe_cnt, dbe_cnt);
        end
        step();
        rst = 0; rd0_req = 0; wr_req = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rd1_vld !== 1'b0) begin
                errors++; $display("FAIL rif_stale_vld[%0d]: got %b expected 0", k, rd1_vld);
            end
            step();
        end
    endtask

`ifdef MDMA_RAM_CTL_SCRUB_EN
    task automatic test_scrub();
        int               cyc;
        int               first_k;
        logic             found;
        logic [ADDR_W-1:0] exp_addr;
        do_reset();
        sbe_at_en = 1; sbe_at = 9'h1FF;
        found = 0; first_k = -1; cyc = 0;
        while (!found && cyc < 40) begin
            @(negedge clk);
            if (ram_if.ren) begin
                found = 1; first_k = cyc; exp_addr = ram_if.radr;
            end
            step();
            cyc++;
        end
        checks++;
        if (!found || first_k != TB_SCRUB_IDLE || exp_addr !== 9'h000) begin
            errors++; $display("FAIL scrub_first: found=%b cycle=%0d addr=%h expected cycle %0d addr 000",
                               found, first_k, exp_addr, TB_SCRUB_IDLE);
        end
        exp_addr = 9'h001; found = 0; cyc = 0;
        while (!found && cyc < 20000) begin
            @(negedge clk);
            if (ram_if.ren) begin
                checks++;
                if (ram_if.radr !== exp_addr) begin
                    errors++; $display("FAIL scrub_addr: got %h expected %h", ram_if.radr, exp_addr);
                end
                if (ram_if.radr == 9'h1FF) found = 1;
                exp_addr = exp_addr + 9'd1;
            end
            step();
            cyc++;
        end
        found = 0; cyc = 0;
        while (!found && cyc < 10) begin
            @(negedge clk);
            if (ram_if.wen) begin
                found = 1;
                checks++;
                if ({ram_if.wadr, ram_if.wdat} !== {9'h1FF, pat(9'h1FF)}) begin
                    errors++; $display("FAIL scrub_wb: got wadr=%h wdat=%h expected 1ff %h",
                                       ram_if.wadr, ram_if.wdat, pat(9'h1FF));
                end
            end
            step();
            cyc++;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL scrub_wb_seen: got no write-back expected one");
        end
        found = 0; cyc = 0;
        while (!found && cyc < 40) begin
            @(negedge clk);
            if (ram_if.ren) begin
                found = 1;
                checks++;
                if ({ram_if.radr, sbe_cnt} !== {9'h000, 16'd1}) begin
                    errors++; $display("FAIL scrub_wrap: got radr=%h sbe=%0d expected 000 1", ram_if.radr, sbe_cnt);
                end
            end
            step();
            cyc++;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL scrub_wrap_seen: got no scrub read expected one");
        end
        sbe_at_en = 0;
    endtask
`else
    task automatic test_no_scrub();
        int rens;
        do_reset();
        rens = 0;
        repeat (40) begin
            @(negedge clk);
            if (ram_if.ren || ram_if.wen) rens++;
            step();
        end
        checks++;
        if (rens != 0) begin
            errors++; $display("FAIL no_scrub: got %0d idle RAM accesses expected 0", rens);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_hazard();
        test_err_count();
        test_saturate();
        test_reset_inflight();
`ifdef MDMA_RAM_CTL_SCRUB_EN
        test_scrub();
`else
        test_no_scrub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
